axis_add_one: RTL and testbench

- AXI4-Stream processing stage. Adds 1 to every byte lane of each accepted beat and forwards it downstream.
- Sits between an upstream stream master and a downstream stream slave in the design_1 block design (replaces the design_1_wrapper core).
- Registered datapath with a 2-entry skid buffer: full throughput, backpressure-safe.

---
 rtl/axis_add_one_if.sv | 16 +
 rtl/axis_add_one.sv | 130 +++++++++++++
 tb/tb_axis_add_one.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_add_one_if.sv
// AXI4-Stream bundle used on both sides of axis_add_one.
// The master drives data and valid. The slave drives ready.
interface axis_add_one_if #(
  parameter int DATA_WIDTH = 32
) ();
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_add_one.sv
// AXI4-Stream stage that adds 1 to every kept byte lane of each beat.
// A main output register is backed by a single skid entry. This gives full
// throughput, and s_axis.tready is registered so that no combinational path
// runs from m_axis.tready back to it.
//
// state | meaning
// EMPTY | no beat held, accepting, output idle
// ONE   | main entry holds the output beat, still accepting
// FULL  | main and skid both hold beats, not accepting
module axis_add_one #(
  parameter int DATA_WIDTH = 32
) (
  input  logic            aclk,
  input  logic            areset,
  axis_add_one_if.slave   s_axis,
  axis_add_one_if.master  m_axis
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [KEEP_WIDTH-1:0] main_keep_q, main_keep_d;
  logic                  main_last_q, main_last_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [KEEP_WIDTH-1:0] skid_keep_q, skid_keep_d;
  logic                  skid_last_q, skid_last_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;

  logic                  s_xfer;
  logic                  m_xfer;
  logic [DATA_WIDTH-1:0] inc_data;

  // Lane-wise increment. Each lane wraps on its own, so no carry crosses a byte.
  function automatic logic [DATA_WIDTH-1:0] add_one(
    input logic [DATA_WIDTH-1:0] d,
    input logic [KEEP_WIDTH-1:0] k
  );
    logic [DATA_WIDTH-1:0] r;
    r = d;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (k[i]) r[8*i +: 8] = d[8*i +: 8] + 8'd1;
    end
    return r;
  endfunction

  assign s_xfer   = s_axis.tvalid & s_ready_q;
  assign m_xfer   = m_valid_q & m_axis.tready;
  assign inc_data = add_one(s_axis.tdata, s_axis.tkeep);

  // Next-state and entry loading for the main/skid buffer.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_keep_d = main_keep_q;
    main_last_d = main_last_q;
    skid_data_d = skid_data_q;
    skid_keep_d = skid_keep_q;
    skid_last_d = skid_last_q;
    case (state_q)
      EMPTY: begin
        if (s_xfer) begin
          main_data_d = inc_data;
          main_keep_d = s_axis.tkeep;
          main_last_d = s_axis.tlast;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (s_xfer && m_xfer) begin
          main_data_d = inc_data;
          main_keep_d = s_axis.tkeep;
          main_last_d = s_axis.tlast;
        end else if (s_xfer) begin
          skid_data_d = inc_data;
          skid_keep_d = s_axis.tkeep;
          skid_last_d = s_axis.tlast;
          state_d     = FULL;
        end else if (m_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (m_xfer) begin
          main_data_d = skid_data_q;
          main_keep_d = skid_keep_q;
          main_last_d = skid_last_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Handshake outputs come straight from the next state, so both of them are registered.
    s_ready_d = (state_d != FULL);
    m_valid_d = (state_d != EMPTY);
  end

  // State and buffer registers. Reset empties everything, and ready stays low until the first edge.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_keep_q <= '0;
      main_last_q <= 1'b0;
      skid_data_q <= '0;
      skid_keep_q <= '0;
      skid_last_q <= 1'b0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_keep_q <= main_keep_d;
      main_last_q <= main_last_d;
      skid_data_q <= skid_data_d;
      skid_keep_q <= skid_keep_d;
      skid_last_q <= skid_last_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign s_axis.tready = s_ready_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = main_data_q;
  assign m_axis.tkeep  = main_keep_q;
  assign m_axis.tlast  = main_last_q;
endmodule

// File: tb/tb_axis_add_one.sv
// Directed testbench for axis_add_one. Expected beats are queued with
// hand-computed values and compared in order at the output.
module tb_axis_add_one;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic areset = 1'b1;

  axis_add_one_if #(.DATA_WIDTH(DW)) s_if ();
  axis_add_one_if #(.DATA_WIDTH(DW)) m_if ();

  axis_add_one #(.DATA_WIDTH(DW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    failures = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit    mon_en = 1'b0;
  bit    check_rdy = 1'b0;
  int    n_out = 0;
  int    waits = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [31:0] e);
    int n;
    n = 0;
    @(negedge aclk);
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    waits += n;
    if (n >= 200) begin
      check("send_timeout", 64'd0, 64'd1);
      s_if.tvalid = 1'b0;
    end else begin
      @(posedge aclk);
      sb.push_back('{data: e, keep: k, last: l});
    end
  endtask

  task automatic idle();
    @(negedge aclk);
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Output side: drive m tready and compare every valid output cycle with the queue head.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(negedge aclk);
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = 1'b0;
      endcase
      if (!areset && mon_en) begin
        if (check_rdy) check("s_tready_vs_fill", 64'(s_if.tready), 64'(sb.size() < 2));
        if (m_if.tvalid) begin
          if (sb.size() == 0) begin
            check("spurious_out", 64'd1, 64'd0);
          end else begin
            check("out_data", 64'(m_if.tdata), 64'(sb[0].data));
            check("out_keep", 64'(m_if.tkeep), 64'(sb[0].keep));
            check("out_last", 64'(m_if.tlast), 64'(sb[0].last));
            if (m_if.tready) begin
              void'(sb.pop_front());
              n_out++;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int n0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;

    // Reset state
    #12;
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_s_tready", 64'(s_if.tready), 64'd0);
    check("rst_m_tdata",  64'(m_if.tdata),  64'd0);
    check("rst_m_tkeep",  64'(m_if.tkeep),  64'd0);
    check("rst_m_tlast",  64'(m_if.tlast),  64'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("s_tready_after_rst", 64'(s_if.tready), 64'd1);
    mon_en    = 1'b1;
    check_rdy = 1'b1;

    // Ramp, no backpressure
    w0 = waits;
    n0 = n_out;
    for (int i = 0; i < 256; i++) begin
      send({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF, 1'b0,
           {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)});
    end
    idle();
    drain();
    check("ramp_stalls", 64'(waits - w0), 64'd0);
    check("ramp_count", 64'(n_out - n0), 64'd256);

    // Lane wrap isolation and keep masking
    send(32'hFFFEFDFC, 4'hF, 1'b0, 32'h00FFFEFD);
    send(32'hFFFFFFFF, 4'hF, 1'b0, 32'h00000000);
    send(32'h00FF00FF, 4'hF, 1'b0, 32'h01000100);
    send(32'h11223344, 4'h5, 1'b0, 32'h11233345);
    send(32'hFFFFFFFF, 4'h0, 1'b1, 32'hFFFFFFFF);
    idle();
    drain();

    // Inputs with tvalid low must be ignored
    @(negedge aclk);
    s_if.tdata = 32'hDEADBEEF;
    repeat (3) @(negedge aclk);
    check("ignored_no_valid", 64'(m_if.tvalid), 64'd0);

    // TLAST only on the fourth beat
    send(32'h00000010, 4'hF, 1'b0, 32'h01010111);
    send(32'h00000020, 4'hF, 1'b0, 32'h01010121);
    send(32'h00000030, 4'hF, 1'b0, 32'h01010131);
    send(32'h00000040, 4'hF, 1'b1, 32'h01010141);
    idle();
    drain();

    // Backpressure with random m_tready
    n0 = n_out;
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) begin
      send(32'(i), 4'hF, 1'b0, 32'(i) + 32'h01010101);
    end
    idle();
    drain();
    rdy_mode = 0;
    check("bp_count", 64'(n_out - n0), 64'd16);

    // Reset with two beats buffered
    rdy_mode = 2;
    @(negedge aclk);
    send(32'h00000001, 4'hF, 1'b0, 32'h01010102);
    send(32'h00000002, 4'hF, 1'b0, 32'h01010103);
    idle();
    check("full_s_tready", 64'(s_if.tready), 64'd0);
    check("full_m_tvalid", 64'(m_if.tvalid), 64'd1);
    #2;
    mon_en    = 1'b0;
    check_rdy = 1'b0;
    areset    = 1'b1;
    #1;
    check("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("mid_rst_s_tready", 64'(s_if.tready), 64'd0);
    check("mid_rst_m_tdata",  64'(m_if.tdata),  64'd0);
    sb.delete();
    repeat (2) @(negedge aclk);
    areset   = 1'b0;
    rdy_mode = 0;
    @(negedge aclk);
    check("s_tready_after_mid_rst", 64'(s_if.tready), 64'd1);
    check("no_stale_after_rst", 64'(m_if.tvalid), 64'd0);
    mon_en    = 1'b1;
    check_rdy = 1'b1;
    n0 = n_out;
    send(32'h0A0B0C0D, 4'hF, 1'b0, 32'h0B0C0D0E);
    idle();
    drain();
    repeat (3) @(negedge aclk);
    check("post_rst_count", 64'(n_out - n0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
